pixel_proc_stream: RTL and testbench
====================================

PIXEL_PROC_STREAM -- requirements
Module: pixel_proc_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 768, pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 512, lines per frame.
REQ-003 SHALL have parameter DW, default 8, bits per colour channel; MAXV = 2^DW-1.
REQ-004 SHALL have port HCLK  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port HRESET  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  frame start request, sampled in IDLE only.
REQ-007 SHALL have port mode  in  3  operation select, latched on accepted start.
REQ-008 SHALL have port value  in  DW  brightness operand, latched on accepted start.
REQ-009 SHALL have port threshold  in  DW  threshold operand, latched on accepted start.
REQ-010 SHALL have ports in_valid  in  1, in_ready  out  1, and in_r/in_g/in_b  in  DW each, forming the input pixel stream.
REQ-011 SHALL have ports out_valid  out  1, out_ready  in  1, and out_r/out_g/out_b  out  DW each, forming the output pixel stream.
REQ-012 SHALL have port out_eol  out  1  marks the last pixel of a line, qualified by out_valid.
REQ-013 SHALL have port out_eof  out  1  marks the last pixel of the frame, qualified by out_valid.
REQ-014 SHALL have ports busy  out  1 (high outside IDLE) and done  out  1 (one-cycle frame-complete pulse).

Function
REQ-015 SHALL implement FSM IDLE->RUN on start; RUN->DRAIN after WIDTH*HEIGHT input transfers; DRAIN->DONE when pipeline empty; DONE->IDLE unconditionally after 1 cycle.
REQ-016 SHALL define input transfer as in_valid&in_ready and output transfer as out_valid&out_ready, both at a rising edge.
REQ-017 SHALL drive in_ready = (state==RUN) & pipeline-advance; in_ready SHALL be low in IDLE, DRAIN and DONE.
REQ-018 SHALL use a 2-stage pipeline advancing when the output stage is empty or out_ready=1; latency SHALL be 2 cycles from input transfer to out_valid with out_ready held high.
REQ-019 SHALL hold out_r/g/b, out_eol and out_eof stable while out_valid=1 and out_ready=0; no pixel SHALL be dropped or duplicated.
REQ-020 SHALL count col 0..WIDTH-1 and row 0..HEIGHT-1 per input transfer, col wrapping to 0 with row increment; the tags SHALL travel with the pixel.
REQ-021 SHALL implement mode 0: bypass.
REQ-022 SHALL implement mode 1: each channel min(x+value, MAXV), computed at DW+1 bits.
REQ-023 SHALL implement mode 2: each channel max(x-value, 0), signed compare at DW+1 bits.
REQ-024 SHALL implement mode 3: gray = floor((R+G+B)/3), summed at DW+2 bits, output on all three channels.
REQ-025 SHALL implement mode 4: all channels MAXV if gray > threshold, else 0.
REQ-026 SHALL implement mode 5: each channel MAXV-x.
REQ-027 SHALL treat modes 6 and 7 as bypass.
REQ-028 SHALL ignore changes on mode/value/threshold during busy; operands used are those latched at start.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL pulse done exactly one cycle, in DONE, after the out_eof pixel has transferred.

Reset
REQ-031 SHALL, on HRESET=1 at a rising edge, force IDLE, clear pipeline and counters, and set in_ready, out_valid, out_eol, out_eof, busy and done to 0; out_r/g/b SHALL reset to 0.
REQ-032 SHALL let HRESET mid-frame abort the frame with no done pulse; the next start SHALL begin at row 0, col 0.

Verification
REQ-033 Bench SHALL cover: DW=8, mode 1, value 100, pixel (200,50,155) -> output (255,150,255), 2 cycles after input transfer with out_ready=1.
REQ-034 Bench SHALL cover: mode 2, value 100, pixel (30,100,250) -> output (0,0,150).
REQ-035 Bench SHALL cover: mode 3 on pixel (10,20,32) -> output (20,20,20); mode 4, threshold 20, same pixel -> output (0,0,0); threshold 19 -> output (255,255,255).
REQ-036 Bench SHALL cover: WIDTH=4, HEIGHT=2, random out_ready stalls -> exactly 8 outputs in order, out_eol on outputs 4 and 8, out_eof on output 8, done one cycle after the 8th transfer.
REQ-037 Bench SHALL cover: HRESET after 3 of 8 pixels -> all outputs 0 next cycle, no done; restart delivers 8 pixels with fresh row/col tags.
REQ-038 Bench SHALL cover: start plus mode change during RUN -> ignored; the frame completes with the originally latched mode.

Source files
------------

// File: rtl/pixel_proc_stream.sv
// Streaming per-pixel colour operator; 2-cycle latency from input transfer to out_valid.
// Backpressure: both stages stall together when the output holds a pixel and out_ready is low.
module pixel_proc_stream #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int DW     = 8
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [DW-1:0] value,
    input  logic [DW-1:0] threshold,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_g,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_g,
    output logic [DW-1:0] out_b,
    output logic          out_eol,
    output logic          out_eof,
    output logic          busy,
    output logic          done
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [DW-1:0]   MAXV   = {DW{1'b1}};
    localparam logic [DW+1:0]   THREE  = {{DW{1'b0}}, 2'b11};
    localparam logic signed [DW:0] ZERO_S = '0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [DW-1:0] r;
        logic [DW-1:0] g;
        logic [DW-1:0] b;
        logic          eol;
        logic          eof;
    } pix_t;

    function automatic logic [DW-1:0] add_sat(input logic [DW-1:0] x, input logic [DW-1:0] v);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, v};
        return s[DW] ? MAXV : s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sub_floor(input logic [DW-1:0] x, input logic [DW-1:0] v);
        logic signed [DW:0] d;
        d = $signed({1'b0, x}) - $signed({1'b0, v});
        return (d < ZERO_S) ? '0 : d[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] gray_of(input logic [DW-1:0] r, input logic [DW-1:0] g,
                                              input logic [DW-1:0] b);
        logic [DW+1:0] s;
        s = {2'b00, r} + {2'b00, g} + {2'b00, b};
        s = s / THREE;
        return s[DW-1:0];
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    mode_q, mode_d;
    logic [DW-1:0] value_q, value_d;
    logic [DW-1:0] thr_q, thr_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          s1_vld_q, s1_vld_d;
    pix_t          s1_q, s1_d;
    logic          out_vld_q, out_vld_d;
    pix_t          out_q, out_d;

    logic          advance;
    logic          in_xfer;
    logic          last_col;
    logic          last_row;
    logic [DW-1:0] gray;
    pix_t          res;

    assign advance  = !out_vld_q || out_ready;
    assign in_ready = (state_q == S_RUN) && advance;
    assign in_xfer  = in_valid && in_ready;
    assign last_col = (col_q == CW'(WIDTH - 1));
    assign last_row = (row_q == RW'(HEIGHT - 1));
    assign gray     = gray_of(s1_q.r, s1_q.g, s1_q.b);

    // Operator stage: works on the registered stage-1 pixel with the operands latched at start
    always_comb begin
        res = s1_q;
        case (mode_q)
            3'd1: begin
                res.r = add_sat(s1_q.r, value_q);
                res.g = add_sat(s1_q.g, value_q);
                res.b = add_sat(s1_q.b, value_q);
            end
            3'd2: begin
                res.r = sub_floor(s1_q.r, value_q);
                res.g = sub_floor(s1_q.g, value_q);
                res.b = sub_floor(s1_q.b, value_q);
            end
            3'd3: begin
                res.r = gray;
                res.g = gray;
                res.b = gray;
            end
            3'd4: begin
                res.r = (gray > thr_q) ? MAXV : '0;
                res.g = (gray > thr_q) ? MAXV : '0;
                res.b = (gray > thr_q) ? MAXV : '0;
            end
            3'd5: begin
                res.r = MAXV - s1_q.r;
                res.g = MAXV - s1_q.g;
                res.b = MAXV - s1_q.b;
            end
            default: res = s1_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        value_d   = value_q;
        thr_d     = thr_q;
        col_d     = col_q;
        row_d     = row_q;
        s1_vld_d  = s1_vld_q;
        s1_d      = s1_q;
        out_vld_d = out_vld_q;
        out_d     = out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    value_d = value;
                    thr_d   = threshold;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                if (in_xfer) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = last_row ? '0 : row_q + RW'(1);
                        if (last_row) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            // Leave as soon as the final pixel leaves the output stage on this edge
            S_DRAIN: begin
                if (!s1_vld_q && advance) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            s1_vld_d  = in_xfer;
            out_vld_d = s1_vld_q;
            if (in_xfer) begin
                s1_d = '{r: in_r, g: in_g, b: in_b, eol: last_col, eof: last_col && last_row};
            end
            if (s1_vld_q) begin
                out_d = res;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            value_q   <= '0;
            thr_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_q      <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            value_q   <= value_d;
            thr_q     <= thr_d;
            col_q     <= col_d;
            row_q     <= row_d;
            s1_vld_q  <= s1_vld_d;
            s1_q      <= s1_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_r     = out_q.r;
    assign out_g     = out_q.g;
    assign out_b     = out_q.b;
    assign out_eol   = out_q.eol;
    assign out_eof   = out_q.eof;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_pixel_proc_stream.sv
// Directed bench for pixel_proc_stream on a 4x2 frame: operator vectors, stalls, abort and restart.
module tb_pixel_proc_stream;

    localparam int DW = 8;

    logic          HCLK;
    logic          HRESET;
    logic          start;
    logic [2:0]    mode;
    logic [DW-1:0] value;
    logic [DW-1:0] threshold;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_r, in_g, in_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r, out_g, out_b;
    logic          out_eol, out_eof, busy, done;

    int n_tests;
    int n_fail;

    logic [23:0] pix_a [8];
    logic [23:0] exp_a [8];

    typedef struct {
        logic [2:0] m;
        logic [7:0] v;
        logic [7:0] t;
        logic [23:0] px;
        logic [23:0] ex;
    } vec_t;

    vec_t vt [11];

    pixel_proc_stream #(.WIDTH(4), .HEIGHT(2), .DW(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode), .value(value),
        .threshold(threshold), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_eol(out_eol), .out_eof(out_eof),
        .busy(busy), .done(done)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // One 8-pixel frame; operands are scrambled and start re-pulsed while busy to show they are ignored
    task automatic run_frame(input logic [2:0] m, input logic [7:0] v, input logic [7:0] t,
                             input bit stall, input int abort_after);
        int in_idx, out_idx, c_in0, done_cnt;
        bit fin, done_pend, hold_pend, seen_ov;
        logic [25:0] held;
        in_idx = 0; out_idx = 0; c_in0 = 0; done_cnt = 0;
        fin = 0; done_pend = 0; hold_pend = 0; seen_ov = 0; held = '0;

        mode = m; value = v; threshold = t; start = 1'b1;
        @(posedge HCLK); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        mode = ~m; value = ~v; threshold = ~t;

        for (int c = 0; c < 300 && !fin; c++) begin
            start    = (out_idx < 8) && (c % 2 == 0);
            in_valid = (in_idx < 8) && (!stall || $urandom_range(0, 3) != 0);
            {in_r, in_g, in_b} = (in_idx < 8) ? pix_a[in_idx] : 24'hA5A5A5;
            out_ready = !stall || ($urandom_range(0, 2) != 0);
            #1;
            if (done) done_cnt++;
            if (done_pend) begin
                chk("done_after_eof", done, 1);
                fin = 1;
            end
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {out_eol, out_eof, out_r, out_g, out_b}, held);
            end
            hold_pend = out_valid && !out_ready;
            held = {out_eol, out_eof, out_r, out_g, out_b};
            if (in_valid && in_ready) begin
                if (in_idx == 0) c_in0 = c;
                in_idx++;
            end
            if (out_valid && !seen_ov) begin
                seen_ov = 1;
                if (!stall) chk("latency", c - c_in0, 2);
            end
            if (out_valid && out_ready) begin
                if (out_idx < 8) begin
                    chk("pixel", {out_r, out_g, out_b}, exp_a[out_idx]);
                    chk("eol", out_eol, (out_idx % 4 == 3));
                    chk("eof", out_eof, (out_idx == 7));
                end else begin
                    chk("extra_output", out_idx, 7);
                end
                out_idx++;
                if (out_idx == 8) done_pend = 1;
            end
            if (abort_after > 0 && in_idx == abort_after) begin
                @(posedge HCLK); #1;
                HRESET = 1'b1; in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
                @(posedge HCLK); #1;
                HRESET = 1'b0;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_in_ready", in_ready, 0);
                chk("abort_busy", busy, 0);
                chk("abort_flags", {out_eol, out_eof, done}, 0);
                chk("abort_data", {out_r, out_g, out_b}, 0);
                for (int k = 0; k < 6; k++) begin
                    @(posedge HCLK); #1;
                    chk("abort_no_done", {done, busy, out_valid}, 0);
                end
                return;
            end
            @(posedge HCLK); #1;
        end

        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        if (!fin) begin
            n_tests++; n_fail++;
            $display("FAIL frame_timeout: got %0d outputs expected 8 plus done", out_idx);
        end
        chk("output_count", out_idx, 8);
        chk("done_pulses", done_cnt, 1);
        @(posedge HCLK); #1;
        chk("idle_after_done", {busy, done}, 0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        HRESET = 1'b1; start = 1'b0; mode = '0; value = '0; threshold = '0;
        in_valid = 1'b0; in_r = '0; in_g = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_ctrl", {out_valid, in_ready, busy, done, out_eol, out_eof}, 0);
        chk("reset_data", {out_r, out_g, out_b}, 0);
        HRESET = 1'b0;
        in_valid = 1'b1;
        @(posedge HCLK); #1;
        chk("idle_in_ready", in_ready, 0);
        chk("idle_out_valid", out_valid, 0);
        in_valid = 1'b0;

        vt[0]  = '{3'd1, 8'd100, 8'd0,  {8'd200, 8'd50,  8'd155}, {8'd255, 8'd150, 8'd255}};
        vt[1]  = '{3'd2, 8'd100, 8'd0,  {8'd30,  8'd100, 8'd250}, {8'd0,   8'd0,   8'd150}};
        vt[2]  = '{3'd3, 8'd0,   8'd0,  {8'd10,  8'd20,  8'd32},  {8'd20,  8'd20,  8'd20}};
        vt[3]  = '{3'd4, 8'd0,   8'd20, {8'd10,  8'd20,  8'd32},  {8'd0,   8'd0,   8'd0}};
        vt[4]  = '{3'd4, 8'd0,   8'd19, {8'd10,  8'd20,  8'd32},  {8'd255, 8'd255, 8'd255}};
        vt[5]  = '{3'd0, 8'd77,  8'd5,  {8'd1,   8'd2,   8'd3},   {8'd1,   8'd2,   8'd3}};
        vt[6]  = '{3'd5, 8'd0,   8'd0,  {8'd0,   8'd100, 8'd255}, {8'd255, 8'd155, 8'd0}};
        vt[7]  = '{3'd6, 8'd50,  8'd0,  {8'd9,   8'd8,   8'd7},   {8'd9,   8'd8,   8'd7}};
        vt[8]  = '{3'd7, 8'd50,  8'd0,  {8'd255, 8'd0,   8'd128}, {8'd255, 8'd0,   8'd128}};
        vt[9]  = '{3'd1, 8'd5,   8'd0,  {8'd10,  8'd250, 8'd0},   {8'd15,  8'd255, 8'd5}};
        vt[10] = '{3'd2, 8'd0,   8'd0,  {8'd0,   8'd1,   8'd2},   {8'd0,   8'd1,   8'd2}};

        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < 8; k++) begin
                pix_a[k] = vt[i].px;
                exp_a[k] = vt[i].ex;
            end
            run_frame(vt[i].m, vt[i].v, vt[i].t, 1'b0, 0);
        end

        for (int k = 0; k < 8; k++) begin
            pix_a[k] = {8'(k * 16 + 1), 8'(k * 16 + 2), 8'(k * 16 + 3)};
            exp_a[k] = pix_a[k];
        end
        run_frame(3'd0, 8'd0, 8'd0, 1'b1, 0);
        run_frame(3'd0, 8'd0, 8'd0, 1'b0, 3);
        run_frame(3'd0, 8'd0, 8'd0, 1'b1, 0);

        for (int k = 0; k < 8; k++) begin
            exp_a[k] = ~pix_a[k];
        end
        run_frame(3'd5, 8'd0, 8'd0, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
